intt_fsm: RTL and testbench

INTT_FSM -- requirements
Module: intt_fsm

---
 rtl/intt_fsm.sv | 184 ++++++++++++++++++
 tb/tb_intt_fsm.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_fsm.sv
// intt_fsm: sequencer for a 512-point inverse NTT built from four radix-4
// stages followed by one radix-2 stage. It generates the butterfly indices,
// the memory read strobe, and the delayed enable and write strobes that
// follow each issue through the butterfly pipeline.
module intt_fsm #(
    parameter int R4_LAT = 14,  // radix-4 read-to-write depth, must be >= 2
    parameter int R2_LAT = 8    // radix-2 read-to-write depth, must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       sel,
    output logic [2:0] p,
    output logic [6:0] k,
    output logic [6:0] j,
    output logic [6:0] i,
    output logic       ren,
    output logic       en,
    output logic       wen,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        R4_RUN   = 3'd1,
        R4_DRAIN = 3'd2,
        R2_RUN   = 3'd3,
        R2_DRAIN = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int DW = 16;

    state_t        state, state_nxt;
    logic [2:0]    p_q, p_nxt;
    logic [6:0]    k_q, k_nxt;
    logic [6:0]    j_q, j_nxt;
    logic [6:0]    i_q, i_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;

    // Per-stage wrap limits; 2p reaches 6 so an 8-bit datapath never overflows.
    logic [3:0]    sh;
    logic [7:0]    jmax, kmax;
    logic          j_last, k_last, r4_last;

    // Issue-type tagged read strobes and their delay lines.
    logic                ren_r4, ren_r2;
    logic [R4_LAT-1:0]   r4_vld_pipe;
    logic [R2_LAT-1:0]   r2_vld_pipe;

    // Stage-dependent wrap points for the radix-4 counters.
    always_comb begin
        sh      = {p_q, 1'b0};
        jmax    = (8'd1 << sh) - 8'd1;
        kmax    = (8'd128 >> sh) - 8'd1;
        j_last  = ({1'b0, j_q} == jmax);
        k_last  = ({1'b0, k_q} == kmax);
        r4_last = (p_q == 3'd3) && j_last && k_last;
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p_q   <= '0;
            k_q   <= '0;
            j_q   <= '0;
            i_q   <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            p_q   <= p_nxt;
            k_q   <= k_nxt;
            j_q   <= j_nxt;
            i_q   <= i_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // Next-state and counter advance.
    always_comb begin
        state_nxt = state;
        p_nxt     = p_q;
        k_nxt     = k_q;
        j_nxt     = j_q;
        i_nxt     = i_q;
        dcnt_nxt  = dcnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = R4_RUN;
                    p_nxt     = '0;
                    k_nxt     = '0;
                    j_nxt     = '0;
                    i_nxt     = '0;
                end
            end
            R4_RUN: begin
                if (r4_last) begin
                    state_nxt = R4_DRAIN;
                    p_nxt     = '0;
                    k_nxt     = '0;
                    j_nxt     = '0;
                    dcnt_nxt  = '0;
                end else if (j_last) begin
                    j_nxt = '0;
                    if (k_last) begin
                        k_nxt = '0;
                        p_nxt = p_q + 3'd1;
                    end else begin
                        k_nxt = k_q + 7'd1;
                    end
                end else begin
                    j_nxt = j_q + 7'd1;
                end
            end
            R4_DRAIN: begin
                // Drain holds R4_LAT+1 cycles so the last radix-4 write lands
                // before the first radix-2 read.
                if (dcnt == DW'(R4_LAT)) begin
                    state_nxt = R2_RUN;
                    i_nxt     = '0;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            R2_RUN: begin
                if (i_q == 7'd127) begin
                    state_nxt = R2_DRAIN;
                    i_nxt     = '0;
                    dcnt_nxt  = '0;
                end else begin
                    i_nxt = i_q + 7'd1;
                end
            end
            R2_DRAIN: begin
                if (dcnt == DW'(R2_LAT)) begin
                    state_nxt = DONE;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read strobe: issue flag delayed one cycle, tagged by butterfly type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_r4 <= 1'b0;
            ren_r2 <= 1'b0;
        end else begin
            ren_r4 <= (state == R4_RUN);
            ren_r2 <= (state == R2_RUN);
        end
    end

    // Delay lines: stage n holds a read issued n+1 cycles ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r4_vld_pipe <= '0;
            r2_vld_pipe <= '0;
        end else begin
            r4_vld_pipe <= {r4_vld_pipe[R4_LAT-2:0], ren_r4};
            r2_vld_pipe <= {r2_vld_pipe[R2_LAT-2:0], ren_r2};
        end
    end

    assign busy = (state != IDLE);
    assign sel  = (state == R4_RUN) || (state == R4_DRAIN);
    assign done = (state == DONE);
    assign p    = p_q;
    assign k    = k_q;
    assign j    = j_q;
    assign i    = i_q;
    assign ren  = ren_r4 | ren_r2;
    assign en   = r4_vld_pipe[R4_LAT-2] | r2_vld_pipe[R2_LAT-2];
    assign wen  = r4_vld_pipe[R4_LAT-1] | r2_vld_pipe[R2_LAT-1];

endmodule

// File: tb/tb_intt_fsm.sv
// tb_intt_fsm: checks two intt_fsm instances (default and short latencies)
// cycle by cycle against a timeline model, plus directed table checks.
module tb_intt_fsm;

    typedef struct packed {
        logic       busy;
        logic       sel;
        logic       ren;
        logic       en;
        logic       wen;
        logic       done;
        logic [2:0] p;
        logic [6:0] k;
        logic [6:0] j;
        logic [6:0] i;
    } obs_t;

    typedef struct {
        int   dut;
        int   cyc;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start;
    always #5 clk = ~clk;

    logic       a_busy, a_sel, a_ren, a_en, a_wen, a_done;
    logic [2:0] a_p;
    logic [6:0] a_k, a_j, a_i;
    logic       b_busy, b_sel, b_ren, b_en, b_wen, b_done;
    logic [2:0] b_p;
    logic [6:0] b_k, b_j, b_i;

    intt_fsm dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(a_busy), .sel(a_sel),
        .p(a_p), .k(a_k), .j(a_j), .i(a_i), .ren(a_ren), .en(a_en),
        .wen(a_wen), .done(a_done)
    );

    intt_fsm #(.R4_LAT(4), .R2_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(b_busy), .sel(b_sel),
        .p(b_p), .k(b_k), .j(b_j), .i(b_i), .ren(b_ren), .en(b_en),
        .wen(b_wen), .done(b_done)
    );

    obs_t obs_a, obs_b;
    assign obs_a = {a_busy, a_sel, a_ren, a_en, a_wen, a_done, a_p, a_k, a_j, a_i};
    assign obs_b = {b_busy, b_sel, b_ren, b_en, b_wen, b_done, b_p, b_k, b_j, b_i};

    int total = 0;
    int bad   = 0;

    int r4l[2] = '{14, 4};
    int r2l[2] = '{8, 3};
    int act[2] = '{0, 0};
    int s0[2]  = '{0, 0};
    int abs_cyc = 0;

    obs_t last_a, last_b;
    obs_t log_a[0:1499];
    obs_t log_b[0:1499];

    function automatic int done_off(int u);
        return 643 + r4l[u] + r2l[u];
    endfunction

    function automatic logic is_r4(int x);
        return (x >= 1) && (x <= 512);
    endfunction

    function automatic logic is_r2(int x, int a2);
        return (x >= a2) && (x <= a2 + 127);
    endfunction

    // Expected outputs d cycles after start was accepted: R4 issues occupy
    // d=1..512, radix-2 issues start after R4_LAT+1 drain cycles.
    function automatic obs_t model(int d, int u);
        obs_t o;
        int   n, pp, m, a2, l4, l2;
        o  = '0;
        l4 = r4l[u];
        l2 = r2l[u];
        a2 = 514 + l4;
        if (d < 1 || d > done_off(u)) return o;
        o.busy = 1'b1;
        o.sel  = (d <= 513 + l4);
        o.done = (d == done_off(u));
        if (d <= 512) begin
            n   = d - 1;
            pp  = n / 128;
            m   = n % 128;
            o.p = 3'(pp);
            o.j = 7'(m % (1 << (2 * pp)));
            o.k = 7'(m / (1 << (2 * pp)));
        end
        if (is_r2(d, a2)) o.i = 7'(d - a2);
        o.ren = is_r4(d - 1) | is_r2(d - 1, a2);
        o.en  = is_r4(d - l4) | is_r2(d - l2, a2);
        o.wen = is_r4(d - 1 - l4) | is_r2(d - 1 - l2, a2);
        return o;
    endfunction

    function automatic obs_t mk(logic b, logic s, logic r, logic e, logic w,
                                logic dn, int pp, int kk, int jj, int ii);
        obs_t o;
        o = {b, s, r, e, w, dn, 3'(pp), 7'(kk), 7'(jj), 7'(ii)};
        return o;
    endfunction

    // One clock cycle: drive, sample mid-cycle, compare both DUTs to the model.
    task automatic tick(input logic r, input logic st);
        obs_t got, ex;
        int   d;
        rst   = r;
        start = st;
        @(negedge clk);
        last_a = obs_a;
        last_b = obs_b;
        for (int u = 0; u < 2; u++) begin
            got = (u == 0) ? obs_a : obs_b;
            d   = act[u] ? (abs_cyc - s0[u]) : -1;
            ex  = r ? obs_t'(0) : model(d, u);
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL model dut%0d cyc=%0d got=%h want=%h", u, abs_cyc, got, ex);
            end
            if (r) act[u] = 0;
            else if (st && (!act[u] || d > done_off(u))) begin
                act[u] = 1;
                s0[u]  = abs_cyc;
            end
        end
        abs_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        vec_t tbl[$];
        bit   seen[int];
        int   stage_cnt[4];
        int   dup, order, rng, prevp, key;
        int   nren, nen, nwen, ndone, nz;
        obs_t o;

        // Full-run timing checkpoints for both latency settings.
        tbl.push_back('{0, 0,   mk(0,0,0,0,0,0, 0,0,0,0)});
        tbl.push_back('{0, 1,   mk(1,1,0,0,0,0, 0,0,0,0)});
        tbl.push_back('{0, 2,   mk(1,1,1,0,0,0, 0,1,0,0)});
        tbl.push_back('{0, 15,  mk(1,1,1,1,0,0, 0,14,0,0)});
        tbl.push_back('{0, 16,  mk(1,1,1,1,1,0, 0,15,0,0)});
        tbl.push_back('{0, 128, mk(1,1,1,1,1,0, 0,127,0,0)});
        tbl.push_back('{0, 129, mk(1,1,1,1,1,0, 1,0,0,0)});
        tbl.push_back('{0, 130, mk(1,1,1,1,1,0, 1,0,1,0)});
        tbl.push_back('{0, 133, mk(1,1,1,1,1,0, 1,1,0,0)});
        tbl.push_back('{0, 512, mk(1,1,1,1,1,0, 3,1,63,0)});
        tbl.push_back('{0, 513, mk(1,1,1,1,1,0, 0,0,0,0)});
        tbl.push_back('{0, 514, mk(1,1,0,1,1,0, 0,0,0,0)});
        tbl.push_back('{0, 526, mk(1,1,0,1,1,0, 0,0,0,0)});
        tbl.push_back('{0, 527, mk(1,1,0,0,1,0, 0,0,0,0)});
        tbl.push_back('{0, 528, mk(1,0,0,0,0,0, 0,0,0,0)});
        tbl.push_back('{0, 529, mk(1,0,1,0,0,0, 0,0,0,1)});
        tbl.push_back('{0, 536, mk(1,0,1,1,0,0, 0,0,0,8)});
        tbl.push_back('{0, 537, mk(1,0,1,1,1,0, 0,0,0,9)});
        tbl.push_back('{0, 655, mk(1,0,1,1,1,0, 0,0,0,127)});
        tbl.push_back('{0, 656, mk(1,0,1,1,1,0, 0,0,0,0)});
        tbl.push_back('{0, 657, mk(1,0,0,1,1,0, 0,0,0,0)});
        tbl.push_back('{0, 663, mk(1,0,0,1,1,0, 0,0,0,0)});
        tbl.push_back('{0, 664, mk(1,0,0,0,1,0, 0,0,0,0)});
        tbl.push_back('{0, 665, mk(1,0,0,0,0,1, 0,0,0,0)});
        tbl.push_back('{0, 666, mk(0,0,0,0,0,0, 0,0,0,0)});
        tbl.push_back('{1, 5,   mk(1,1,1,1,0,0, 0,4,0,0)});
        tbl.push_back('{1, 6,   mk(1,1,1,1,1,0, 0,5,0,0)});
        tbl.push_back('{1, 517, mk(1,1,0,0,1,0, 0,0,0,0)});
        tbl.push_back('{1, 518, mk(1,0,0,0,0,0, 0,0,0,0)});
        tbl.push_back('{1, 519, mk(1,0,1,0,0,0, 0,0,0,1)});
        tbl.push_back('{1, 521, mk(1,0,1,1,0,0, 0,0,0,3)});
        tbl.push_back('{1, 522, mk(1,0,1,1,1,0, 0,0,0,4)});
        tbl.push_back('{1, 646, mk(1,0,1,1,1,0, 0,0,0,0)});
        tbl.push_back('{1, 649, mk(1,0,0,0,1,0, 0,0,0,0)});
        tbl.push_back('{1, 650, mk(1,0,0,0,0,1, 0,0,0,0)});
        tbl.push_back('{1, 651, mk(0,0,0,0,0,0, 0,0,0,0)});

        rst   = 1'b1;
        start = 1'b0;
        tick(1, 0);
        tick(1, 1);
        tick(0, 0);
        tick(0, 0);

        // Full run with a stray start in the middle.
        for (int c = 0; c < 700; c++) begin
            tick(0, (c == 0) || (c == 300));
            log_a[c] = last_a;
            log_b[c] = last_b;
        end
        foreach (tbl[n]) begin
            o = (tbl[n].dut == 0) ? log_a[tbl[n].cyc] : log_b[tbl[n].cyc];
            total++;
            if (o !== tbl[n].exp) begin
                bad++;
                $display("FAIL tbl dut%0d cyc=%0d got=%h want=%h",
                         tbl[n].dut, tbl[n].cyc, o, tbl[n].exp);
            end
        end
        nren = 0; nen = 0; nwen = 0;
        for (int c = 0; c < 700; c++) begin
            nren += int'(log_a[c].ren);
            nen  += int'(log_a[c].en);
            nwen += int'(log_a[c].wen);
        end
        chk("ren_total", nren, 640);
        chk("en_total", nen, 640);
        chk("wen_total", nwen, 640);
        dup = 0; order = 0; rng = 0; prevp = 0;
        for (int s = 0; s < 4; s++) stage_cnt[s] = 0;
        for (int c = 1; c <= 512; c++) begin
            o   = log_a[c];
            key = int'(o.p) * 65536 + int'(o.k) * 128 + int'(o.j);
            if (seen.exists(key)) dup++;
            seen[key] = 1'b1;
            if (o.p < 4) stage_cnt[o.p]++;
            if (int'(o.p) < prevp) order++;
            prevp = int'(o.p);
            if (int'(o.j) >= (1 << (2 * int'(o.p))) || int'(o.k) >= (128 >> (2 * int'(o.p)))) rng++;
        end
        for (int s = 0; s < 4; s++) chk($sformatf("stage%0d_len", s), stage_cnt[s], 128);
        chk("tuple_dup", dup, 0);
        chk("p_order", order, 0);
        chk("kj_range", rng, 0);

        // start held high: one full run, then a second starting at 667.
        for (int c = 0; c < 1400; c++) begin
            tick(0, c <= 700);
            log_a[c] = last_a;
        end
        ndone = 0;
        for (int c = 0; c < 1400; c++) ndone += int'(log_a[c].done);
        chk("held_done_cnt", ndone, 2);
        chk("held_done1", int'(log_a[665].done), 1);
        chk("held_idle", int'(log_a[666].busy), 0);
        chk("held_rerun", int'(log_a[667].busy), 1);
        chk("held_done2", int'(log_a[1331].done), 1);

        // Mid-run reset, then a fresh start at 210.
        for (int c = 0; c < 900; c++) begin
            tick((c >= 200) && (c <= 204), (c == 0) || (c == 210));
            log_a[c] = last_a;
            log_b[c] = last_b;
        end
        nz = 0; nwen = 0;
        for (int c = 200; c <= 210; c++) begin
            if (log_a[c] != '0 || log_b[c] != '0) nz++;
            nwen += int'(log_a[c].wen) + int'(log_b[c].wen);
        end
        chk("rst_quiet", nz, 0);
        chk("rst_wen", nwen, 0);
        chk("rst_run_busy", int'(log_a[211].busy), 1);
        chk("rst_last_r4wen", int'(log_a[737].wen), 1);
        chk("rst_sel_fall", int'(log_a[738].sel), 0);
        chk("rst_done", int'(log_a[875].done), 1);
        chk("rst_idle", int'(log_a[876].busy), 0);

        // Random starts and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            tick($urandom_range(0, 699) == 0, $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
